// File: rtl/seg2axis_pack.sv
// ---------------------------------------------------------------------------
// seg2axis_pack
//
// Converts the segmented MAC RX interface into AXI-stream. Each input beat
// carries SEG_COUNT segments. DATA and EOP segments are compacted, in lane
// order, into a circular segment buffer. The read side emits one AXI-stream
// beat per frame chunk: up to SEG_COUNT entries, ending early at the first EOP.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_mac_valid          input beat valid
//   rx_mac_data           segment i at [i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]
//   rx_mac_inframe        segment i carries frame data and the frame continues
//   rx_mac_eop_empty      unused bytes in an EOP segment, EMPTY_WIDTH per lane
//   rx_mac_fcs_error      FCS error per segment
//   rx_mac_error          2-bit MAC error code per segment
//   rx_mac_ready          buffer can absorb a full beat (registered pointers only)
//   m_axis_*              AXI-stream master; tuser = frame bad (on tlast beat)
//   status_overflow       one-cycle pulse: an input beat was dropped
//
// Handshake: an input beat is taken on an edge where rx_mac_valid and
// rx_mac_ready are both high; a beat offered while rx_mac_ready is low is
// dropped. An output beat transfers on an edge where m_axis_tvalid and
// m_axis_tready are both high; while m_axis_tvalid is high and m_axis_tready
// is low, every m_axis_* output holds its value.
// ---------------------------------------------------------------------------
module seg2axis_pack #(
    parameter int SEG_COUNT      = 16,
    parameter int SEG_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = SEG_COUNT * SEG_DATA_WIDTH,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int EMPTY_WIDTH    = $clog2(SEG_DATA_WIDTH / 8),
    parameter int BUF_SEGS       = 4 * SEG_COUNT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx_mac_valid,
    input  logic [DATA_WIDTH-1:0]            rx_mac_data,
    input  logic [SEG_COUNT-1:0]             rx_mac_inframe,
    input  logic [EMPTY_WIDTH*SEG_COUNT-1:0] rx_mac_eop_empty,
    input  logic [SEG_COUNT-1:0]             rx_mac_fcs_error,
    input  logic [2*SEG_COUNT-1:0]           rx_mac_error,
    output logic                             rx_mac_ready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    output logic                             status_overflow
);

    localparam int SEG_BYTES = SEG_DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(BUF_SEGS);
    localparam int PTR_W     = IDX_W + 1;          // extra bit separates full from empty
    localparam int CNT_W     = $clog2(SEG_COUNT + 1);

    // Segment buffer (storage only, no reset needed: only entries between
    // rd_ptr and wr_ptr are ever read).
    logic [SEG_DATA_WIDTH-1:0] buf_data_q [BUF_SEGS];
    logic [SEG_DATA_WIDTH-1:0] buf_data_d [BUF_SEGS];
    logic [SEG_BYTES-1:0]      buf_keep_q [BUF_SEGS];
    logic [SEG_BYTES-1:0]      buf_keep_d [BUF_SEGS];
    logic [BUF_SEGS-1:0]       buf_eop_q, buf_eop_d;
    logic [BUF_SEGS-1:0]       buf_err_q, buf_err_d;

    // Control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             prev_inframe_q, prev_inframe_d;
    logic             pending_err_q, pending_err_d;
    logic             err_acc_q, err_acc_d;
    logic             overflow_q, overflow_d;

    // Output register
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;

    // Occupancy / ready
    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] free_segs;
    logic             beat_accept;
    logic             beat_drop;

    // Write-side temporaries
    logic [CNT_W-1:0]          wr_cnt;
    logic [IDX_W-1:0]          wr_idx;
    logic                      seg_prev;
    logic                      seg_eop;
    logic [SEG_DATA_WIDTH-1:0] seg_data;
    logic [SEG_BYTES-1:0]      seg_keep;
    logic [EMPTY_WIDTH-1:0]    seg_empty;
    logic                      pend_left;

    // Read-side temporaries
    logic [IDX_W-1:0]      rd_idx;
    logic                  chunk_found;
    logic [CNT_W-1:0]      chunk_len;
    logic                  chunk_err;
    logic [DATA_WIDTH-1:0] chunk_data;
    logic [KEEP_WIDTH-1:0] chunk_keep;
    logic                  chunk_ready;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign free_segs = PTR_W'(BUF_SEGS) - occupancy;
    // Held low while in reset; otherwise depends on registered pointers only.
    assign rx_mac_ready = rst_n && (free_segs >= PTR_W'(SEG_COUNT));
    assign beat_accept  = rx_mac_valid && rx_mac_ready;
    assign beat_drop    = rx_mac_valid && !rx_mac_ready;

    // -----------------------------------------------------------------------
    // Write side: classify and compact segments into the buffer.
    // -----------------------------------------------------------------------
    always_comb begin
        buf_data_d = buf_data_q;
        buf_keep_d = buf_keep_q;
        buf_eop_d  = buf_eop_q;
        buf_err_d  = buf_err_q;
        wr_cnt     = '0;
        wr_idx     = '0;
        seg_prev   = prev_inframe_q;
        seg_eop    = 1'b0;
        seg_data   = '0;
        seg_keep   = '0;
        seg_empty  = '0;
        pend_left  = pending_err_q;

        for (int i = 0; i < SEG_COUNT; i++) begin
            seg_eop   = !rx_mac_inframe[i] && seg_prev;
            seg_empty = rx_mac_eop_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
            seg_data  = rx_mac_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
            for (int b = 0; b < SEG_BYTES; b++) begin
                seg_keep[b] = !seg_eop || (b < (SEG_BYTES - int'(seg_empty)));
                if (!seg_keep[b]) begin
                    seg_data[b*8 +: 8] = 8'h00;
                end
            end

            if (beat_accept && (rx_mac_inframe[i] || seg_eop)) begin
                wr_idx             = wr_ptr_q[IDX_W-1:0] + IDX_W'(wr_cnt);
                buf_data_d[wr_idx] = seg_data;
                buf_keep_d[wr_idx] = seg_keep;
                buf_eop_d[wr_idx]  = seg_eop;
                // A dropped beat's damage belongs to whichever frame the next
                // stored segment is part of, so it is folded in only once.
                buf_err_d[wr_idx]  = (|rx_mac_error[2*i +: 2]) | rx_mac_fcs_error[i] | pend_left;
                pend_left          = 1'b0;
                wr_cnt             = wr_cnt + CNT_W'(1);
            end
            seg_prev = rx_mac_inframe[i];
        end

        wr_ptr_d       = wr_ptr_q + PTR_W'(wr_cnt);
        pending_err_d  = beat_drop ? 1'b1 : pend_left;
        prev_inframe_d = rx_mac_valid ? rx_mac_inframe[SEG_COUNT-1] : prev_inframe_q;
        overflow_d     = beat_drop;
    end

    // -----------------------------------------------------------------------
    // Read side: gather the next chunk starting at rd_ptr.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_idx      = '0;
        chunk_found = 1'b0;
        chunk_len   = '0;
        chunk_err   = 1'b0;
        chunk_data  = '0;
        chunk_keep  = '0;

        for (int k = 0; k < SEG_COUNT; k++) begin
            rd_idx = rd_ptr_q[IDX_W-1:0] + IDX_W'(k);
            if (!chunk_found && (PTR_W'(k) < occupancy)) begin
                chunk_data[k*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = buf_data_q[rd_idx];
                chunk_keep[k*SEG_BYTES +: SEG_BYTES]           = buf_keep_q[rd_idx];
                chunk_err   = chunk_err | buf_err_q[rd_idx];
                chunk_len   = CNT_W'(k + 1);
                chunk_found = buf_eop_q[rd_idx];
            end
        end

        chunk_ready = chunk_found || (occupancy >= PTR_W'(SEG_COUNT));
    end

    // -----------------------------------------------------------------------
    // Output register load
    // -----------------------------------------------------------------------
    always_comb begin
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        rd_ptr_d  = rd_ptr_q;
        err_acc_d = err_acc_q;

        if (!tvalid_q || m_axis_tready) begin
            tvalid_d = chunk_ready;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            if (chunk_ready) begin
                tdata_d  = chunk_data;
                tkeep_d  = chunk_keep;
                tlast_d  = chunk_found;
                rd_ptr_d = rd_ptr_q + PTR_W'(chunk_len);
                // Frame error is sticky across chunks and reported on tlast.
                if (chunk_found) begin
                    tuser_d   = err_acc_q | chunk_err;
                    err_acc_d = 1'b0;
                end else begin
                    err_acc_d = err_acc_q | chunk_err;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_keep_q <= buf_keep_d;
        buf_eop_q  <= buf_eop_d;
        buf_err_q  <= buf_err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            prev_inframe_q <= 1'b0;
            pending_err_q  <= 1'b0;
            err_acc_q      <= 1'b0;
            overflow_q     <= 1'b0;
            tdata_q        <= '0;
            tkeep_q        <= '0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            tuser_q        <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            prev_inframe_q <= prev_inframe_d;
            pending_err_q  <= pending_err_d;
            err_acc_q      <= err_acc_d;
            overflow_q     <= overflow_d;
            tdata_q        <= tdata_d;
            tkeep_q        <= tkeep_d;
            tvalid_q       <= tvalid_d;
            tlast_q        <= tlast_d;
            tuser_q        <= tuser_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tkeep    = tkeep_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tuser    = tuser_q;
    assign status_overflow = overflow_q;

endmodule
